lmsm_sequencer: RTL and testbench

Parametrised load-multiple/store-multiple sequencer for the RISC datapath. Latches a register mask and base address on start, then issues one register index plus memory address per accepted beat. Scan order is selectable (ascending or descending), and each beat waits on a memory-ready handshake. Sits between the decode stage and the register-file and memory ports, and stalls the fetch while busy.

---
 rtl/lmsm_sequencer_if.sv | 34 +++
 rtl/lmsm_sequencer.sv | 129 ++++++++++++
 tb/tb_lmsm_sequencer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/lmsm_sequencer_if.sv
// Bundle between the decode stage, the LM/SM sequencer and the register-file/memory ports.
// The master side issues requests and memory-ready; the slave side is the sequencer.
interface lmsm_sequencer_if #(
    parameter int NREGS  = 8,
    parameter int IDX_W  = 3,
    parameter int ADDR_W = 16
);
    logic              start;
    logic [NREGS-1:0]  mask;
    logic [ADDR_W-1:0] base_addr;
    logic              is_store;
    logic              descending;
    logic              mem_ready;

    logic              busy;
    logic              xfer_valid;
    logic [IDX_W-1:0]  xfer_idx;
    logic [ADDR_W-1:0] xfer_addr;
    logic              reg_we;
    logic              mem_we;
    logic              last;
    logic              done;
    logic              empty_mask;

    modport master (
        output start, mask, base_addr, is_store, descending, mem_ready,
        input  busy, xfer_valid, xfer_idx, xfer_addr, reg_we, mem_we, last, done, empty_mask
    );

    modport slave (
        input  start, mask, base_addr, is_store, descending, mem_ready,
        output busy, xfer_valid, xfer_idx, xfer_addr, reg_we, mem_we, last, done, empty_mask
    );
endinterface

// File: rtl/lmsm_sequencer.sv
// Load-multiple/store-multiple sequencer: walks a latched register mask in the selected
// order and issues one register index plus memory address per accepted beat.
module lmsm_sequencer #(
    parameter int NREGS  = 8,
    parameter int IDX_W  = 3,
    parameter int ADDR_W = 16,
    parameter int STEP   = 1
) (
    input  logic            clk,
    input  logic            reset,
    lmsm_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(STEP);

    state_t            state, state_nxt;
    logic [NREGS-1:0]  rem_mask, rem_mask_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic              store_q, store_nxt;
    logic              desc_q, desc_nxt;
    logic              empty_q, empty_nxt;

    logic [IDX_W-1:0]  cur_idx;
    logic              cur_last;
    logic              accept;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [NREGS-1:0] m);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (m[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [IDX_W-1:0] highest_set(input logic [NREGS-1:0] m);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (m[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic single_bit(input logic [NREGS-1:0] m);
        return (m != '0) && ((m & (m - NREGS'(1))) == '0);
    endfunction

    // Priority encode straight off the remaining-mask register so a stall holds idx/last.
    assign cur_idx  = desc_q ? highest_set(rem_mask) : lowest_set(rem_mask);
    assign cur_last = single_bit(rem_mask);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            rem_mask <= '0;
            addr     <= '0;
            store_q  <= 1'b0;
            desc_q   <= 1'b0;
            empty_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            rem_mask <= rem_mask_nxt;
            addr     <= addr_nxt;
            store_q  <= store_nxt;
            desc_q   <= desc_nxt;
            empty_q  <= empty_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        rem_mask_nxt   = rem_mask;
        addr_nxt       = addr;
        store_nxt      = store_q;
        desc_nxt       = desc_q;
        empty_nxt      = empty_q;
        accept         = 1'b0;
        bus.busy       = 1'b0;
        bus.xfer_valid = 1'b0;
        bus.xfer_idx   = '0;
        bus.xfer_addr  = '0;
        bus.reg_we     = 1'b0;
        bus.mem_we     = 1'b0;
        bus.last       = 1'b0;
        bus.done       = 1'b0;
        bus.empty_mask = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    rem_mask_nxt = bus.mask;
                    addr_nxt     = bus.base_addr;
                    store_nxt    = bus.is_store;
                    desc_nxt     = bus.descending;
                    empty_nxt    = (bus.mask == '0);
                    state_nxt    = (bus.mask == '0) ? S_DONE : S_XFER;
                end
            end
            S_XFER: begin
                accept         = bus.mem_ready;
                bus.busy       = 1'b1;
                bus.xfer_valid = 1'b1;
                bus.xfer_idx   = cur_idx;
                bus.xfer_addr  = addr;
                bus.last       = cur_last;
                bus.reg_we     = accept & ~store_q;
                bus.mem_we     = accept & store_q;
                // Address wraps modulo 2^ADDR_W in either direction.
                if (accept) begin
                    rem_mask_nxt = rem_mask & ~(NREGS'(1) << cur_idx);
                    addr_nxt     = desc_q ? (addr - STEP_A) : (addr + STEP_A);
                    if (cur_last) state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                bus.done       = 1'b1;
                bus.empty_mask = empty_q;
                state_nxt      = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed table-driven bench for lmsm_sequencer plus a hand-written asynchronous-reset sequence.
module tb_lmsm_sequencer;
    localparam int NREGS  = 8;
    localparam int IDX_W  = 3;
    localparam int ADDR_W = 16;

    typedef struct {
        string             name;
        logic              start;
        logic [NREGS-1:0]  mask;
        logic [ADDR_W-1:0] base;
        logic              store;
        logic              desc;
        logic              rdy;
        logic              busy;
        logic              valid;
        logic [IDX_W-1:0]  idx;
        logic [ADDR_W-1:0] addr;
        logic              rwe;
        logic              mwe;
        logic              last;
        logic              done;
        logic              empty;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    vec_t vecs[$];

    lmsm_sequencer_if #(.NREGS(NREGS), .IDX_W(IDX_W), .ADDR_W(ADDR_W)) bus ();

    lmsm_sequencer #(.NREGS(NREGS), .IDX_W(IDX_W), .ADDR_W(ADDR_W), .STEP(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        if ((1 << IDX_W) < NREGS) begin
            $display("FAIL param_check: 2**IDX_W=%0d is below NREGS=%0d", 1 << IDX_W, NREGS);
            $fatal(1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic void add(string n, logic st, logic [NREGS-1:0] m, logic [ADDR_W-1:0] b,
                                logic s, logic d, logic r, logic bz, logic v, logic [IDX_W-1:0] i,
                                logic [ADDR_W-1:0] a, logic rw, logic mw, logic l, logic dn, logic e);
        vec_t t;
        t.name = n;   t.start = st; t.mask = m;  t.base = b;  t.store = s; t.desc = d; t.rdy = r;
        t.busy = bz;  t.valid = v;  t.idx = i;   t.addr = a;  t.rwe = rw;  t.mwe = mw;
        t.last = l;   t.done = dn;  t.empty = e;
        vecs.push_back(t);
    endfunction

    task automatic chk(string what, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", what, act, exp);
        end
    endtask

    task automatic chk_all(string tag, logic bz, logic v, logic [IDX_W-1:0] i, logic [ADDR_W-1:0] a,
                           logic rw, logic mw, logic l, logic dn, logic e);
        chk({tag, ".busy"},       32'(bus.busy),       32'(bz));
        chk({tag, ".xfer_valid"}, 32'(bus.xfer_valid), 32'(v));
        chk({tag, ".xfer_idx"},   32'(bus.xfer_idx),   32'(i));
        chk({tag, ".xfer_addr"},  32'(bus.xfer_addr),  32'(a));
        chk({tag, ".reg_we"},     32'(bus.reg_we),     32'(rw));
        chk({tag, ".mem_we"},     32'(bus.mem_we),     32'(mw));
        chk({tag, ".last"},       32'(bus.last),       32'(l));
        chk({tag, ".done"},       32'(bus.done),       32'(dn));
        chk({tag, ".empty_mask"}, 32'(bus.empty_mask), 32'(e));
    endtask

    task automatic drive(logic st, logic [NREGS-1:0] m, logic [ADDR_W-1:0] b, logic s, logic d, logic r);
        bus.start      = st;
        bus.mask       = m;
        bus.base_addr  = b;
        bus.is_store   = s;
        bus.descending = d;
        bus.mem_ready  = r;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        //   name          st mask         base      s  d  r   bz v  idx addr      rw mw l  dn e
        add("asc_start",   1, 8'b1010_0101, 16'h0100, 0, 0, 1,  0, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
        add("asc_b0",      0, 8'h00,        16'h0000, 0, 0, 1,  1, 1, 0, 16'h0100, 1, 0, 0, 0, 0);
        add("asc_b1",      0, 8'h00,        16'h0000, 0, 0, 1,  1, 1, 2, 16'h0101, 1, 0, 0, 0, 0);
        add("asc_b2",      0, 8'h00,        16'h0000, 0, 0, 1,  1, 1, 5, 16'h0102, 1, 0, 0, 0, 0);
        add("asc_b3",      0, 8'h00,        16'h0000, 0, 0, 1,  1, 1, 7, 16'h0103, 1, 0, 1, 0, 0);
        add("asc_done",    0, 8'h00,        16'h0000, 0, 0, 1,  0, 0, 0, 16'h0000, 0, 0, 0, 1, 0);
        add("desc_start",  1, 8'b1010_0101, 16'h0100, 1, 1, 1,  0, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
        add("desc_b0",     0, 8'h00,        16'h0000, 0, 0, 1,  1, 1, 7, 16'h0100, 0, 1, 0, 0, 0);
        add("desc_b1",     0, 8'h00,        16'h0000, 0, 0, 1,  1, 1, 5, 16'h00FF, 0, 1, 0, 0, 0);
        add("desc_b2",     0, 8'h00,        16'h0000, 0, 0, 1,  1, 1, 2, 16'h00FE, 0, 1, 0, 0, 0);
        add("desc_b3",     0, 8'h00,        16'h0000, 0, 0, 1,  1, 1, 0, 16'h00FD, 0, 1, 1, 0, 0);
        add("desc_done",   0, 8'h00,        16'h0000, 0, 0, 1,  0, 0, 0, 16'h0000, 0, 0, 0, 1, 0);
        add("empty_start", 1, 8'h00,        16'h0055, 0, 0, 1,  0, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
        add("empty_done",  0, 8'h00,        16'h0000, 0, 0, 1,  0, 0, 0, 16'h0000, 0, 0, 0, 1, 1);
        add("empty_idle",  0, 8'h00,        16'h0000, 0, 0, 1,  0, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
        add("wrap_start",  1, 8'b0000_0011, 16'hFFFF, 0, 0, 0,  0, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
        add("wrap_stall0", 0, 8'h00,        16'h0000, 0, 0, 0,  1, 1, 0, 16'hFFFF, 0, 0, 0, 0, 0);
        add("wrap_stall1", 0, 8'h00,        16'h0000, 0, 0, 0,  1, 1, 0, 16'hFFFF, 0, 0, 0, 0, 0);
        add("wrap_b0",     0, 8'h00,        16'h0000, 0, 0, 1,  1, 1, 0, 16'hFFFF, 1, 0, 0, 0, 0);
        add("wrap_b1",     0, 8'h00,        16'h0000, 0, 0, 1,  1, 1, 1, 16'h0000, 1, 0, 1, 0, 0);
        add("wrap_done",   0, 8'h00,        16'h0000, 0, 0, 1,  0, 0, 0, 16'h0000, 0, 0, 0, 1, 0);
        add("busy_start",  1, 8'h81,        16'h0020, 0, 0, 1,  0, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
        add("busy_b0",     1, 8'hFF,        16'h0500, 1, 1, 1,  1, 1, 0, 16'h0020, 1, 0, 0, 0, 0);
        add("busy_b1",     1, 8'hFF,        16'h0500, 1, 1, 1,  1, 1, 7, 16'h0021, 1, 0, 1, 0, 0);
        add("busy_done",   1, 8'hFF,        16'h0500, 1, 1, 1,  0, 0, 0, 16'h0000, 0, 0, 0, 1, 0);
        add("busy_idle",   0, 8'h00,        16'h0000, 0, 0, 1,  0, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
        add("b2b_start",   1, 8'h10,        16'h0030, 0, 0, 1,  0, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
        add("b2b_b0",      0, 8'h00,        16'h0000, 0, 0, 1,  1, 1, 4, 16'h0030, 1, 0, 1, 0, 0);
        add("b2b_done",    0, 8'h00,        16'h0000, 0, 0, 1,  0, 0, 0, 16'h0000, 0, 0, 0, 1, 0);
        add("b2b_idle",    0, 8'h00,        16'h0000, 0, 0, 1,  0, 0, 0, 16'h0000, 0, 0, 0, 0, 0);

        reset = 1'b0;
        drive(0, '0, '0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all("reset", 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[k]) begin
            drive(vecs[k].start, vecs[k].mask, vecs[k].base, vecs[k].store, vecs[k].desc, vecs[k].rdy);
            @(negedge clk);
            chk_all(vecs[k].name, vecs[k].busy, vecs[k].valid, vecs[k].idx, vecs[k].addr,
                    vecs[k].rwe, vecs[k].mwe, vecs[k].last, vecs[k].done, vecs[k].empty);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset during beat 2 of a 4-beat load, then a fresh operation.
        drive(1, 8'h0F, 16'h0200, 0, 0, 1);
        @(negedge clk);
        chk_all("rst_start", 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        drive(0, '0, '0, 0, 0, 1);
        @(negedge clk);
        chk_all("rst_b0", 1, 1, 0, 16'h0200, 1, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_all("rst_b1", 1, 1, 1, 16'h0201, 1, 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        chk_all("rst_async", 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all("rst_held", 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_all("rst_idle", 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        drive(1, 8'h04, 16'h0010, 0, 0, 1);
        @(negedge clk);
        chk_all("post_start", 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        drive(0, '0, '0, 0, 0, 1);
        @(negedge clk);
        chk_all("post_b0", 1, 1, 2, 16'h0010, 1, 0, 1, 0, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_all("post_done", 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_all("post_idle", 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
